// File: rtl/sub8_sched_pkg.sv
// Shared types and constants for the sub8 result-checker scheduler.
package sub8_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] FAIL_BEAT_TMO = 16'hFFFF;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub8_cmp_sched_rr_arb.sv
// N-way round-robin arbiter: first requester strictly after i_ptr, with wrap-around.
module rr_arb
  import sub8_sched_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = chan_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_vld
);

  int            w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    w_sum = 0;
    w_idx = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = PW'(w_sum);
      if (!o_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_vld        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sub8_cmp_sched.sv
// Round-robin scheduler sharing one 8-lane result checker between NCH channels,
// with sticky first-failure capture and a stall watchdog.
module sub8_cmp_sched
  import sub8_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 8,
  parameter int BEATS = 64,
  parameter int TMO   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NCH-1:0]            ch_vld,
  input  logic [NCH*WIDTH*8-1:0]    ch_data,
  output logic [NCH-1:0]            ch_rdy,
  output logic                      ovld,
  output logic [WIDTH*8-1:0]        odata,
  output logic [chan_w(NCH)-1:0]    ochan,
  input  logic                      ordy,
  input  logic                      cmp_err,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic                      tmo,
  output logic [chan_w(NCH)-1:0]    fail_chan,
  output logic [15:0]               fail_beat
);

  localparam int          CW      = chan_w(NCH);
  localparam int          BW      = WIDTH * 8;
  localparam int          WW      = $clog2(TMO + 1);
  localparam logic [15:0] BEATS_W = 16'(BEATS);

  state_e        r_state;
  logic [15:0]   r_count [NCH];
  logic [CW-1:0] r_ptr;
  logic [WW-1:0] r_wdog;
  logic          r_ovld;
  logic [BW-1:0] r_odata;
  logic [CW-1:0] r_ochan;
  logic [15:0]   r_obeat;
  logic [CW-1:0] r_last_chan;
  logic [15:0]   r_last_beat;
  logic          r_hs_prev;
  logic          r_fail;
  logic          r_tmo;
  logic [CW-1:0] r_fail_chan;
  logic [15:0]   r_fail_beat;

  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_gnt;
  logic           w_gvld;
  logic [CW-1:0]  w_gidx;
  logic           w_hs;
  logic           w_tmo_hit;
  logic           w_load;
  logic           w_accept;
  logic           w_all_done;
  logic           w_err_take;
  logic [BW-1:0]  w_beat;

  // Grant stage: combinational from registered state plus ch_vld.
  always_comb begin
    w_hs       = r_ovld && ordy;
    w_tmo_hit  = (r_state == S_RUN) && !w_hs && (r_wdog == WW'(TMO - 1));
    w_load     = (r_state == S_RUN) && !w_tmo_hit && (!r_ovld || ordy);
    w_err_take = ((r_state == S_RUN) || (r_state == S_DRAIN)) && cmp_err && !r_fail;
    w_all_done = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      w_elig[i] = ch_vld[i] && (r_count[i] < BEATS_W);
      if (r_count[i] != BEATS_W) w_all_done = 1'b0;
    end
  end

  rr_arb #(
    .N  (NCH),
    .PW (CW)
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_vld (w_gvld)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt[i]) w_gidx = CW'(i);
    end
  end

  assign w_accept = w_load && w_gvld;
  assign ch_rdy   = w_gnt & {NCH{w_accept}};
  assign w_beat   = ch_data[int'(w_gidx)*BW +: BW];

  // Output register stage plus control/status; a timeout cycle never accepts a beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < NCH; i++) r_count[i] <= '0;
      r_ptr       <= '0;
      r_wdog      <= '0;
      r_ovld      <= 1'b0;
      r_odata     <= '0;
      r_ochan     <= '0;
      r_obeat     <= '0;
      r_last_chan <= '0;
      r_last_beat <= '0;
      r_hs_prev   <= 1'b0;
      r_fail      <= 1'b0;
      r_tmo       <= 1'b0;
      r_fail_chan <= '0;
      r_fail_beat <= '0;
    end else begin
      r_hs_prev <= w_hs;
      if (w_hs) begin
        r_last_chan <= r_ochan;
        r_last_beat <= r_obeat;
      end

      if (w_accept) begin
        r_ovld          <= 1'b1;
        r_odata         <= w_beat;
        r_ochan         <= w_gidx;
        r_obeat         <= r_count[w_gidx];
        r_count[w_gidx] <= r_count[w_gidx] + 16'd1;
        r_ptr           <= w_gidx;
      end else if (w_hs || w_tmo_hit) begin
        r_ovld <= 1'b0;
      end

      if (w_err_take) begin
        r_fail      <= 1'b1;
        r_fail_chan <= r_last_chan;
        r_fail_beat <= r_last_beat;
      end else if (w_tmo_hit && !r_fail) begin
        r_fail_chan <= r_ptr;
        r_fail_beat <= FAIL_BEAT_TMO;
      end
      if (w_tmo_hit) begin
        r_fail <= 1'b1;
        r_tmo  <= 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            for (int i = 0; i < NCH; i++) r_count[i] <= '0;
            r_ptr       <= CW'(NCH - 1);
            r_wdog      <= '0;
            r_fail      <= 1'b0;
            r_tmo       <= 1'b0;
            r_fail_chan <= '0;
            r_fail_beat <= '0;
          end
        end
        S_RUN: begin
          r_wdog <= w_hs ? '0 : r_wdog + 1'b1;
          if (w_tmo_hit)       r_state <= S_DONE;
          else if (w_all_done) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // The checker's cmp_err for the final beat lands one cycle after its handshake.
          if (!r_ovld && !r_hs_prev) r_state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  assign ovld      = r_ovld;
  assign odata     = r_odata;
  assign ochan     = r_ochan;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign fail      = r_fail;
  assign tmo       = r_tmo;
  assign fail_chan = r_fail_chan;
  assign fail_beat = r_fail_beat;

endmodule

// File: tb/tb_sub8_cmp_sched.sv
// Bench for sub8_cmp_sched: table-driven full-rate run, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_sub8_cmp_sched;

  localparam int WIDTH = 16;
  localparam int NCH   = 8;
  localparam int BEATS = 4;
  localparam int TMO   = 16;
  localparam int BW    = WIDTH * 8;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NCH-1:0]    ch_vld;
  logic [NCH*BW-1:0] ch_data;
  logic [NCH-1:0]    ch_rdy;
  logic              ovld;
  logic [BW-1:0]     odata;
  logic [CW-1:0]     ochan;
  logic              ordy;
  logic              cmp_err;
  logic              busy;
  logic              done;
  logic              fail;
  logic              tmo;
  logic [CW-1:0]     fail_chan;
  logic [15:0]       fail_beat;

  always #5 clk = ~clk;

  sub8_cmp_sched #(.WIDTH(WIDTH), .NCH(NCH), .BEATS(BEATS), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_vld(ch_vld), .ch_data(ch_data),
    .ch_rdy(ch_rdy), .ovld(ovld), .odata(odata), .ochan(ochan), .ordy(ordy),
    .cmp_err(cmp_err), .busy(busy), .done(done), .fail(fail), .tmo(tmo),
    .fail_chan(fail_chan), .fail_beat(fail_beat)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
  int            m_ph, m_last_g, m_och, m_obeat, m_quiet, m_lc, m_lb, m_fc, m_fb;
  int            m_cnt [NCH];
  bit            m_ov, m_hsprev, m_fail, m_tmo;
  logic [BW-1:0] m_od;
  logic [31:0]   salt;
  int            sb_cnt [NCH];
  int            sb_total;

  function automatic logic [BW-1:0] mk_data(input int c, input int b);
    return {salt, 32'(c), 32'(b), salt ^ 32'hC0DE_5A5A};
  endfunction

  function automatic bit m_timeout();
    return (m_ph == 1) && !(m_ov && ordy) && (m_quiet + 1 >= TMO);
  endfunction

  function automatic int m_grant();
    if (m_ph != 1 || (m_ov && !ordy) || m_timeout()) return -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_last_g + k) % NCH;
      if (ch_vld[c] && m_cnt[c] < BEATS) return c;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ph = 0; m_last_g = 0; m_ov = 0; m_och = 0; m_obeat = 0; m_od = '0;
    m_quiet = 0; m_hsprev = 0; m_lc = 0; m_lb = 0;
    m_fail = 0; m_tmo = 0; m_fc = 0; m_fb = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  endtask

  task automatic m_enter();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]  = 0;
      sb_cnt[i] = 0;
    end
    sb_total = 0;
    m_fail = 0; m_tmo = 0; m_fc = 0; m_fb = 0;
    m_last_g = NCH - 1; m_quiet = 0; m_ph = 1;
    salt = $urandom;
  endtask

  task automatic m_step();
    bit hs, to, err, full, drain_ok;
    int g, ph0;
    if (!rst) begin
      m_reset();
      return;
    end
    hs  = m_ov && ordy;
    to  = m_timeout();
    g   = m_grant();
    ph0 = m_ph;
    err = (ph0 == 1 || ph0 == 2) && cmp_err && !m_fail;
    drain_ok = !m_ov && !m_hsprev;
    full = 1;
    for (int i = 0; i < NCH; i++) if (m_cnt[i] != BEATS) full = 0;
    if (err) begin
      m_fail = 1; m_fc = m_lc; m_fb = m_lb;
    end else if (to && !m_fail) begin
      m_fc = m_last_g; m_fb = 16'hFFFF;
    end
    if (to) begin m_fail = 1; m_tmo = 1; end
    if (hs) begin m_lc = m_och; m_lb = m_obeat; end
    if (g >= 0) begin
      m_ov = 1; m_och = g; m_obeat = m_cnt[g]; m_od = mk_data(g, m_cnt[g]);
      m_cnt[g]++; m_last_g = g;
    end else if (hs || to) begin
      m_ov = 0;
    end
    m_hsprev = hs;
    if (ph0 == 1) m_quiet = hs ? 0 : m_quiet + 1;
    case (ph0)
      0, 3: if (start) m_enter();
      1: if (to) m_ph = 3; else if (full) m_ph = 2;
      2: if (drain_ok) m_ph = 3;
      default: ;
    endcase
  endtask

  task automatic drive_data();
    for (int c = 0; c < NCH; c++) ch_data[c*BW +: BW] = mk_data(c, m_cnt[c]);
  endtask

  task automatic settle();
    int g;
    logic [NCH-1:0] er;
    drive_data();
    #1;
    g  = m_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ch_rdy", BW'(ch_rdy), BW'(er));
    chk("ovld", BW'(ovld), BW'(m_ov));
    if (m_ov) begin
      chk("ochan", BW'(ochan), BW'(m_och));
      chk("odata", odata, m_od);
    end
    chk("status", BW'({busy, done, fail, tmo, fail_chan, fail_beat}),
        BW'({(m_ph == 1 || m_ph == 2), (m_ph == 3), m_fail, m_tmo, 3'(m_fc), 16'(m_fb)}));
    if (ovld && ordy) begin
      int c;
      c = int'(ochan);
      chk("sb_beat", BW'(odata[63:32]), BW'(sb_cnt[c]));
      sb_cnt[c]++;
      sb_total++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic check_full_run(input string nm);
    chk({nm, "_total"}, BW'(sb_total), BW'(NCH * BEATS));
    for (int c = 0; c < NCH; c++) chk({nm, "_per_ch"}, BW'(sb_cnt[c]), BW'(BEATS));
  endtask

  typedef struct {
    logic           start;
    logic [NCH-1:0] vld;
    logic           ordy;
    logic [NCH-1:0] exp_rdy;
    logic           exp_ovld;
    logic [CW-1:0]  exp_ochan;
    logic           exp_busy;
    logic           exp_done;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t tab [37];
    int   n, last_hs;
    logic nerr;

    for (int k = 0; k < 37; k++) begin
      tab[k].start     = (k == 0);
      tab[k].vld       = '1;
      tab[k].ordy      = 1'b1;
      tab[k].exp_rdy   = (k >= 1 && k <= 32) ? (8'(1) << ((k - 1) % 8)) : 8'h00;
      tab[k].exp_ovld  = (k >= 2 && k <= 33);
      tab[k].exp_ochan = (k >= 2 && k <= 33) ? CW'((k - 2) % 8) : '0;
      tab[k].exp_busy  = (k >= 1 && k <= 35);
      tab[k].exp_done  = (k >= 36);
    end

    rst = 1'b0; start = 1'b0; ch_vld = '0; ordy = 1'b0; cmp_err = 1'b0; salt = '0;
    m_reset();
    drive_data();
    tick();
    tick();
    settle();
    chk("reset_outputs", BW'({ch_rdy, ovld, busy, done, fail, tmo, fail_chan, fail_beat, ochan}), '0);
    chk("reset_odata", odata, '0);
    tick();
    rst = 1'b1;

    // Full-rate run from the stimulus table.
    for (int k = 0; k < 37; k++) begin
      start = tab[k].start; ch_vld = tab[k].vld; ordy = tab[k].ordy;
      settle();
      chk("t1_rdy", BW'(ch_rdy), BW'(tab[k].exp_rdy));
      chk("t1_ovld", BW'(ovld), BW'(tab[k].exp_ovld));
      if (tab[k].exp_ovld) chk("t1_ochan", BW'(ochan), BW'(tab[k].exp_ochan));
      chk("t1_busy_done", BW'({busy, done}), BW'({tab[k].exp_busy, tab[k].exp_done}));
      tick();
    end
    chk("t1_fail", BW'(fail), '0);
    check_full_run("t1");

    // ordy toggling 1,0,1,0 with every channel valid.
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      ordy = (n % 2 == 0);
      cyc();
      n++;
    end
    chk("t2_done", BW'(done), BW'(1));
    chk("t2_fail", BW'(fail), '0);
    check_full_run("t2");

    // Checker errors: ch3 beat 2 first, then ch5 beat 3.
    ordy = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      settle();
      nerr = ovld && ordy && ((ochan == 3'd3 && odata[63:32] == 32'd2) ||
                              (ochan == 3'd5 && odata[63:32] == 32'd3));
      tick();
      cmp_err = nerr;
      n++;
    end
    cmp_err = 1'b0;
    chk("t3_done", BW'(done), BW'(1));
    chk("t3_fail", BW'({fail, tmo}), BW'(2'b10));
    chk("t3_fail_chan", BW'(fail_chan), BW'(3));
    chk("t3_fail_beat", BW'(fail_beat), BW'(2));
    check_full_run("t3");

    // Only channel 6 active: four beats then watchdog timeout.
    ch_vld = 8'h40; start = 1'b1; cyc(); start = 1'b0;
    n = 0; last_hs = -100;
    while (done !== 1'b1 && n < 200) begin
      settle();
      if (ovld && ordy) last_hs = n;
      tick();
      n++;
    end
    chk("t4_done", BW'(done), BW'(1));
    chk("t4_fail_tmo", BW'({fail, tmo, ovld}), BW'(3'b110));
    chk("t4_fail_chan", BW'(fail_chan), BW'(6));
    chk("t4_fail_beat", BW'(fail_beat), BW'(16'hFFFF));
    chk("t4_beats", BW'(sb_cnt[6]), BW'(BEATS));
    chk("t4_latency", BW'(n - last_hs), BW'(17));

    // Restart from DONE after a failure; a mid-run start must be ignored.
    ch_vld = '1; start = 1'b1; cyc(); start = 1'b0;
    settle();
    chk("t5_cleared", BW'({fail, tmo, busy}), BW'(3'b001));
    chk("t5_first_rdy", BW'(ch_rdy), BW'(8'h01));
    tick();
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      start = (n == 10);
      cyc();
      n++;
    end
    start = 1'b0;
    chk("t6_done", BW'(done), BW'(1));
    chk("t6_fail", BW'(fail), '0);
    check_full_run("t6");

    // Reset mid-run while the output register holds a beat.
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("t7_pre_ovld", BW'(ovld), BW'(1));
    rst = 1'b0; cyc(); rst = 1'b1;
    settle();
    chk("t7_reset_outputs", BW'({ch_rdy, ovld, busy, done, fail, tmo, fail_chan, fail_beat, ochan}), '0);
    chk("t7_reset_odata", odata, '0);
    tick();
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    chk("t7_done", BW'(done), BW'(1));
    chk("t7_fail", BW'(fail), '0);
    check_full_run("t7");

    // Randomized traffic, checker stalls, errors, stray starts and resets.
    for (int r = 0; r < 6; r++) begin
      ch_vld = 8'($urandom); start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 120; i++) begin
        ch_vld  = (r % 2 == 0) ? 8'($urandom | $urandom) : 8'($urandom);
        ordy    = ($urandom_range(0, 3) != 0);
        cmp_err = ($urandom_range(0, 19) == 0);
        start   = ($urandom_range(0, 49) == 0);
        rst     = ($urandom_range(0, 199) != 0);
        cyc();
      end
      rst = 1'b1; start = 1'b0; cmp_err = 1'b0;
    end
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub8_cmp_sched.md
Name: sub8_cmp_sched

Overview:
Round-robin scheduler that shares one 8-word result checker between NCH sub-channel result streams.
- Each channel offers packed 8-lane beats (WIDTH*8 bits) with valid/ready.
- The block grants channels fairly, counts BEATS beats per channel, and forwards each beat with its channel id to the single checker port.
- It aggregates the checker's mismatch reports into a sticky fail status with channel/beat location, plus a stall watchdog.

Parameters:
- WIDTH, 16, bits per lane; a beat is WIDTH*8 bits.
- NCH, 8, number of requesting channels (2..16).
- BEATS, 64, beats expected per channel per run (1..65535).
- TMO, 1024, max cycles in RUN without a checker handshake before a timeout fail.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- ch_vld  in  NCH  per-channel beat valid.
- ch_data  in  NCH*WIDTH*8  channel i beat at bits [i*WIDTH*8 +: WIDTH*8].
- ch_rdy  out  NCH  per-channel accept; at most one bit high (one-hot).
- ovld  out  1  beat valid to checker.
- odata  out  WIDTH*8  beat to checker.
- ochan  out  $clog2(NCH)  source channel of odata.
- ordy  in  1  checker ready.
- cmp_err  in  1  checker mismatch for the beat handshaken on the previous cycle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- fail  out  1  sticky fail.
- tmo  out  1  sticky timeout flag; a subset of fail.
- fail_chan  out  $clog2(NCH)  channel of the first failure.
- fail_beat  out  16  beat index (0-based) of the first failure.

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All outputs 0. Beat counters, round-robin pointer, watchdog counter, last_chan and last_beat all cleared.
- States: IDLE -> RUN on start. RUN -> DRAIN when every channel count == BEATS. DRAIN -> DONE when ovld=0 and no handshake occurred in the previous cycle (cmp_err window closed). DONE -> RUN on start. start is ignored in RUN and DRAIN.
- Entering RUN: clears counters, fail, tmo, fail_chan, fail_beat. The pointer resets to NCH-1, so channel 0 has first priority.
- Output stage: single register. load = (ovld==0 || ordy==1) in RUN.
- Eligible channel: ch_vld[i]=1 and count[i] < BEATS.
- Grant: the first eligible channel searching from ptr+1 upward with wrap-around. It is combinational from registered state plus ch_vld.
- ch_rdy[g] = load && grant_valid. On ch_vld[g] && ch_rdy[g]: odata <= beat, ochan <= g, ovld <= 1, count[g]++, ptr <= g.
- Handshake ovld && ordy without a new load: ovld <= 0 next cycle.
- While ovld=1 && ordy=0: odata and ochan held stable. Latency is channel accept -> ovld 1 cycle; back-to-back beats at full rate are allowed.
- On each ovld && ordy: last_chan <= ochan and last_beat <= count[ochan] at the time of that channel's accept. This means storing the beat index alongside odata.
- cmp_err is sampled only in RUN or DRAIN. If cmp_err=1 and fail=0: fail <= 1, fail_chan <= last_chan, fail_beat <= last_beat. Later errors are ignored; the first failure wins.
- Watchdog: in RUN the counter increments each cycle and resets on any checker handshake. On reaching TMO: fail <= 1, tmo <= 1, fail_chan <= ptr, fail_beat <= 16'hFFFF, and state goes to DONE. The output register is discarded (ovld <= 0).
- fail does not abort the run; only a timeout does.
- A channel that reaches BEATS gets ch_rdy=0 permanently for the run, even if ch_vld stays high.
- Reset mid-run returns to IDLE with all state cleared; there is no partial recovery.
- Counter width: 16 bits; BEATS is never exceeded.

Decomposition:
- Package sub8_sched_pkg holds:
  - state enum {S_IDLE, S_RUN, S_DRAIN, S_DONE}, 2 bits;
  - localparam function for the channel-id width;
  - FAIL_BEAT_TMO = 16'hFFFF.
- One sub-module: rr_arb, a parameterised N-way round-robin grant given req and ptr, outputting one-hot grant plus valid. It is purely combinational; the pointer lives in the parent.

Test Plan:
- NCH=8, BEATS=4, all ch_vld=1, ordy=1 -> grant order 0,1,...,7 repeated 4 times; 32 consecutive ovld cycles; ochan 0..7 cyclic; done=1 two cycles after the last handshake; fail=0.
- Same run, ordy toggled 1,0,1,0 -> odata/ochan stable while ordy=0; no beat lost or duplicated (checker scoreboard sees 32 beats, 4 per channel).
- cmp_err=1 one cycle after channel 3's beat 2 handshake, then again on channel 5 -> fail=1, fail_chan=3, fail_beat=2; run still reaches DONE.
- Only ch_vld[6]=1 with the rest idle, TMO=16 -> 4 beats from channel 6, then 16 idle cycles -> tmo=1, fail=1, fail_chan=6, fail_beat=16'hFFFF, done=1.
- rst=0 asserted for one cycle mid-RUN with ovld=1 -> next cycle all outputs 0 and state IDLE. A subsequent start runs the full 32 beats cleanly.
- start pulsed during RUN -> ignored, counters unchanged. start in DONE -> fail/tmo cleared and a new run begins with channel 0 first.
